// File: rtl/uivtc_txsrc.sv
// Video timing generator and pixel source for the HDMI/DVI transmitter (PCLKX1_i domain).
// Define UIVTC_TXSRC_PATTERN_EN to drive RGB_o from internal colour bars instead of RGB_i.
module uivtc_txsrc #(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 110,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 220,
  parameter int   V_ACTIVE = 720,
  parameter int   V_FP     = 5,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 20,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic        PCLKX1_i,
  input  logic        RST_i,
  input  logic        EN_i,
  input  logic [23:0] RGB_i,
  output logic        PIX_REQ_o,
  output logic [11:0] X_o,
  output logic [11:0] Y_o,
  output logic        VS_o,
  output logic        HS_o,
  output logic        VDE_o,
  output logic [23:0] RGB_o,
  output logic        FRAME_START_o,
  output logic        BUSY_o,
  output logic [1:0]  dbg_state
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 4095 || V_TOTAL > 4095) begin : g_total_check
    $error("uivtc_txsrc: H_TOTAL or V_TOTAL exceeds the 12-bit counter range");
  end

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  logic [1:0]  state;
  logic [11:0] hc;
  logic [11:0] vc;
  logic        counting;
  logic        line_end;
  logic        frame_end;
  logic        active;
  logic        h_sync;
  logic        v_sync;

  assign counting  = (state != ST_IDLE);
  assign line_end  = (hc == H_LAST);
  assign frame_end = line_end && (vc == V_LAST);
  assign active    = (hc < H_ACT) && (vc < V_ACT);
  assign h_sync    = (hc >= HS_BEG) && (hc < HS_END);
  assign v_sync    = (vc >= VS_BEG) && (vc < VS_END);

  assign BUSY_o    = counting;
  assign dbg_state = state;

  // STOP only falls back to IDLE on the last cycle of a frame, so a frame is never torn.
  always_ff @(posedge PCLKX1_i or posedge RST_i) begin
    if (RST_i) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (EN_i) state <= ST_RUN;
        ST_RUN:  if (!EN_i) state <= ST_STOP;
        ST_STOP: begin
          if (EN_i)           state <= ST_RUN;
          else if (frame_end) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLKX1_i or posedge RST_i) begin
    if (RST_i) begin
      hc <= '0;
      vc <= '0;
    end else if (!counting) begin
      hc <= '0;
      vc <= '0;
    end else if (line_end) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? 12'd0 : vc + 12'd1;
    end else begin
      hc <= hc + 12'd1;
    end
  end

  // Pixel request contract: PIX_REQ_o is a one-cycle strobe with no back-pressure;
  // the source must present the addressed pixel on RGB_i in the following cycle.
  logic hs1, vs1, fs1;
  logic de2, hs2, vs2, fs2;

  always_ff @(posedge PCLKX1_i or posedge RST_i) begin
    if (RST_i) begin
      PIX_REQ_o <= 1'b0;
      X_o       <= '0;
      Y_o       <= '0;
      hs1       <= ~HS_POL;
      vs1       <= ~VS_POL;
      fs1       <= 1'b0;
    end else begin
      PIX_REQ_o <= counting && active;
      if (counting && active) begin
        X_o <= hc;
        Y_o <= vc;
      end
      hs1 <= (counting && h_sync) ? HS_POL : ~HS_POL;
      vs1 <= (counting && v_sync) ? VS_POL : ~VS_POL;
      fs1 <= counting && active && (hc == 12'd0) && (vc == 12'd0);
    end
  end

  always_ff @(posedge PCLKX1_i or posedge RST_i) begin
    if (RST_i) begin
      de2 <= 1'b0;
      hs2 <= ~HS_POL;
      vs2 <= ~VS_POL;
      fs2 <= 1'b0;
    end else begin
      de2 <= PIX_REQ_o;
      hs2 <= hs1;
      vs2 <= vs1;
      fs2 <= fs1;
    end
  end

  logic [23:0] pix_src;

`ifdef UIVTC_TXSRC_PATTERN_EN
  localparam int          BAR_W    = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);

  logic [11:0] bar_cnt;
  logic [2:0]  bar_idx;
  logic [23:0] bar_rgb;
  logic [23:0] col1;
  logic [23:0] col2;
  logic        unused_rgb_i;

  assign unused_rgb_i = ^RGB_i;

  // bar_idx tracks hc; the last bar holds index 7 for the rest of the line.
  always_ff @(posedge PCLKX1_i or posedge RST_i) begin
    if (RST_i) begin
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (!counting || line_end) begin
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (bar_cnt == BAR_LAST && bar_idx != 3'd7) begin
      bar_cnt <= '0;
      bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_cnt <= bar_cnt + 12'd1;
    end
  end

  always_comb begin
    bar_rgb = 24'h000000;
    case (bar_idx)
      3'd0: bar_rgb = 24'hFFFFFF;
      3'd1: bar_rgb = 24'hFFFF00;
      3'd2: bar_rgb = 24'h00FFFF;
      3'd3: bar_rgb = 24'h00FF00;
      3'd4: bar_rgb = 24'hFF00FF;
      3'd5: bar_rgb = 24'hFF0000;
      3'd6: bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  // Two delay stages keep the pattern latency identical to the external-source path.
  always_ff @(posedge PCLKX1_i or posedge RST_i) begin
    if (RST_i) begin
      col1 <= '0;
      col2 <= '0;
    end else begin
      col1 <= bar_rgb;
      col2 <= col1;
    end
  end

  assign pix_src = col2;
`else
  assign pix_src = RGB_i;
`endif

  always_ff @(posedge PCLKX1_i or posedge RST_i) begin
    if (RST_i) begin
      VDE_o         <= 1'b0;
      HS_o          <= ~HS_POL;
      VS_o          <= ~VS_POL;
      FRAME_START_o <= 1'b0;
      RGB_o         <= '0;
    end else begin
      VDE_o         <= de2;
      HS_o          <= hs2;
      VS_o          <= vs2;
      FRAME_START_o <= fs2;
      RGB_o         <= de2 ? pix_src : 24'h000000;
    end
  end

endmodule
